// File: rtl/serial_pe_feeder_if.sv
// Buffer-read and PE-operand bundle between serial_pe_feeder (master) and the
// neuron/weight SRAMs plus serial_pe (slave).
interface serial_pe_feeder_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic              n_rd_en;
  logic [ADDR_W-1:0] n_addr;
  logic [15:0]       n_rdata;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_addr;
  logic [15:0]       w_rdata;
  logic [15:0]       pe_neuron;
  logic [15:0]       pe_weight;
  logic [1:0]        pe_ctl;
  logic              pe_vld;

  modport master (
    output n_rd_en, n_addr, w_rd_en, w_addr, pe_neuron, pe_weight, pe_ctl, pe_vld,
    input  n_rdata, w_rdata
  );

  modport slave (
    input  n_rd_en, n_addr, w_rd_en, w_addr, pe_neuron, pe_weight, pe_ctl, pe_vld,
    output n_rdata, w_rdata
  );
endinterface

// File: rtl/serial_pe_feeder.sv
// Operand sequencer for serial_pe: streams num_vec dot products of vec_len pairs.
// Optional hold-stall counter enabled by SERIAL_PE_FEEDER_HOLD_CNT_EN.
module serial_pe_feeder #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LEN_W-1:0]    vec_len,
  input  logic [LEN_W-1:0]    num_vec,
  input  logic [ADDR_W-1:0]   neuron_base,
  input  logic [ADDR_W-1:0]   weight_base,
  input  logic                hold,
  serial_pe_feeder_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic [31:0]         hold_cycles
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  vec_len_q, vec_len_d;
  logic [LEN_W-1:0]  num_vec_q, num_vec_d;
  logic [ADDR_W-1:0] neuron_base_q, neuron_base_d;
  logic [ADDR_W-1:0] weight_base_q, weight_base_d;
  logic [LEN_W-1:0]  i_q, i_d;
  logic [LEN_W-1:0]  j_q, j_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic              pe_vld_q, pe_vld_d;
  logic [1:0]        pe_ctl_q, pe_ctl_d;

  logic accept;
  logic issue;
  logic i_last;
  logic j_last;

  assign accept = (state_q == StIdle) && start;
  assign issue  = (state_q == StRun) && !hold;
  assign i_last = (i_q == vec_len_q - LEN_W'(1));
  assign j_last = (j_q == num_vec_q - LEN_W'(1));

  always_comb begin
    state_d       = state_q;
    vec_len_d     = vec_len_q;
    num_vec_d     = num_vec_q;
    neuron_base_d = neuron_base_q;
    weight_base_d = weight_base_q;
    i_d           = i_q;
    j_d           = j_q;
    wptr_d        = wptr_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          vec_len_d     = vec_len;
          num_vec_d     = num_vec;
          neuron_base_d = neuron_base;
          weight_base_d = weight_base;
          i_d           = '0;
          j_d           = '0;
          wptr_d        = '0;
          state_d       = ((vec_len == '0) || (num_vec == '0)) ? StDone : StRun;
        end
      end
      StRun: begin
        if (!hold) begin
          wptr_d = wptr_q + ADDR_W'(1);
          if (i_last) begin
            i_d = '0;
            j_d = j_q + LEN_W'(1);
            if (j_last) state_d = StDrain;
          end else begin
            i_d = i_q + LEN_W'(1);
          end
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ctl is zeroed on idle beats so the PE never sees a stray first/last flag.
  always_comb begin
    pe_vld_d = issue;
    pe_ctl_d = issue ? {i_last, (i_q == '0)} : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      vec_len_q     <= '0;
      num_vec_q     <= '0;
      neuron_base_q <= '0;
      weight_base_q <= '0;
      i_q           <= '0;
      j_q           <= '0;
      wptr_q        <= '0;
      pe_vld_q      <= 1'b0;
      pe_ctl_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      vec_len_q     <= vec_len_d;
      num_vec_q     <= num_vec_d;
      neuron_base_q <= neuron_base_d;
      weight_base_q <= weight_base_d;
      i_q           <= i_d;
      j_q           <= j_d;
      wptr_q        <= wptr_d;
      pe_vld_q      <= pe_vld_d;
      pe_ctl_q      <= pe_ctl_d;
    end
  end

  assign bus.n_rd_en   = issue;
  assign bus.w_rd_en   = issue;
  assign bus.n_addr    = issue ? (neuron_base_q + ADDR_W'(i_q)) : '0;
  assign bus.w_addr    = issue ? (weight_base_q + wptr_q) : '0;
  assign bus.pe_neuron = bus.n_rdata;
  assign bus.pe_weight = bus.w_rdata;
  assign bus.pe_vld    = pe_vld_q;
  assign bus.pe_ctl    = pe_ctl_q;

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

`ifdef SERIAL_PE_FEEDER_HOLD_CNT_EN
  logic [31:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (accept) begin
      hold_cnt_d = '0;
    end else if ((state_q == StRun) && hold && (hold_cnt_q != 32'hFFFF_FFFF)) begin
      hold_cnt_d = hold_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt_q <= '0;
    else        hold_cnt_q <= hold_cnt_d;
  end

  assign hold_cycles = hold_cnt_q;
`else
  assign hold_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_serial_pe_feeder.sv
// Self-checking bench for serial_pe_feeder: table vectors, hand sequences and random jobs
// compared against a beat-schedule reference model.
module tb_serial_pe_feeder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  vec_len;
  logic [7:0]  num_vec;
  logic [15:0] neuron_base;
  logic [15:0] weight_base;
  logic        hold;
  logic        busy;
  logic        done;
  logic [31:0] hold_cycles;

  int checks   = 0;
  int failures = 0;

  serial_pe_feeder_if #(.ADDR_W(16)) bus ();

  serial_pe_feeder #(.ADDR_W(16), .LEN_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .vec_len     (vec_len),
    .num_vec     (num_vec),
    .neuron_base (neuron_base),
    .weight_base (weight_base),
    .hold        (hold),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .hold_cycles (hold_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] nfun(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] wfun(input logic [15:0] a);
    logic [15:0] r;
    r = a * 16'd13;
    return r + 16'h0101;
  endfunction

  // Synchronous SRAM models with one-cycle read latency.
  always_ff @(posedge clk) begin
    if (bus.n_rd_en) bus.n_rdata <= nfun(bus.n_addr);
    if (bus.w_rd_en) bus.w_rdata <= wfun(bus.w_addr);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one job starting in the next cycle and checks every cycle until IDLE.
  // Model: issues fall on the first N cycles >= 1 without hold; each beat k has
  // element i = k % L, neuron address nb+i and weight address wb+k.
  task automatic run_job(input int l, input int m, input logic [15:0] nb,
                         input logic [15:0] wb, input logic [63:0] hmask,
                         input int exp_done, input int exp_hold, input string tag);
    int beat_at[256];
    int n, k, c, last, done_c, obs_done, pb, ib, model_hold;
    logic iss, pv;
    logic [1:0] ctl;
    logic [15:0] na, wa, pna, pwa;
    for (int x = 0; x < 256; x++) beat_at[x] = -1;
    n = l * m;
    k = 0;
    c = 1;
    last = 0;
    while (k < n && c < 250) begin
      if (!(c < 64 && hmask[c])) begin
        beat_at[c] = k;
        last = c;
        k++;
      end
      c++;
    end
    done_c = (n == 0) ? 1 : last + 2;
    model_hold = (n == 0) ? 0 : last - n;
    obs_done = -1;

    @(posedge clk); #1;
    start = 1'b1;
    vec_len = 8'(l);
    num_vec = 8'(m);
    neuron_base = nb;
    weight_base = wb;
    hold = hmask[0];

    for (int cy = 1; cy <= done_c + 1; cy++) begin
      @(posedge clk); #1;
      start = 1'b0;
      hold = (cy < 64) ? hmask[cy] : 1'b0;
      #1;
      iss = (beat_at[cy] >= 0);
      pb  = beat_at[cy-1];
      pv  = (pb >= 0);
      ctl = 2'b00;
      if (pv) begin
        ib  = pb % l;
        ctl = {(ib == l - 1), (ib == 0)};
        pna = nb + 16'(ib);
        pwa = wb + 16'(pb);
        check($sformatf("%s c%0d pe_data", tag, cy), {bus.pe_neuron, bus.pe_weight},
              {nfun(pna), wfun(pwa)});
      end
      check($sformatf("%s c%0d ctrl", tag, cy),
            {bus.n_rd_en, bus.w_rd_en, bus.pe_vld, bus.pe_ctl, done, busy},
            {iss, iss, pv, ctl, (cy == done_c), (cy <= done_c)});
      if (iss) begin
        na = nb + 16'(beat_at[cy] % l);
        wa = wb + 16'(beat_at[cy]);
        check($sformatf("%s c%0d addr", tag, cy), {bus.n_addr, bus.w_addr}, {na, wa});
      end
      if (done && obs_done < 0) obs_done = cy;
    end

`ifdef SERIAL_PE_FEEDER_HOLD_CNT_EN
    check({tag, " hold_cycles"}, hold_cycles, model_hold);
    if (exp_hold >= 0) check({tag, " hold_cycles_tab"}, hold_cycles, exp_hold);
`else
    check({tag, " hold_cycles"}, hold_cycles, 0);
`endif
    if (exp_done >= 0) check({tag, " done_cycle"}, obs_done, exp_done);
  endtask

  typedef struct {
    int          vl;
    int          nv;
    logic [15:0] nb;
    logic [15:0] wb;
    logic [63:0] hmask;
    int          exp_done;
    int          exp_hold;
  } vec_t;

  vec_t tab[8];

  initial begin
    tab[0] = '{4, 2, 16'h0010, 16'h0100, 64'h0,  10, 0};  // basic job
    tab[1] = '{1, 3, 16'h0020, 16'h0200, 64'h0,   5, 0};  // every beat first+last
    tab[2] = '{0, 5, 16'h0030, 16'h0300, 64'h0,   1, 0};  // zero length
    tab[3] = '{4, 2, 16'h0010, 16'h0100, 64'hC,  12, 2};  // hold in cycles 2-3
    tab[4] = '{4, 1, 16'h0040, 16'hFFFE, 64'h0,   6, 0};  // weight address wrap
    tab[5] = '{3, 0, 16'h0050, 16'h0500, 64'h0,   1, 0};  // zero vectors
    tab[6] = '{0, 2, 16'h0060, 16'h0600, 64'h3,   1, 0};  // hold outside RUN
    tab[7] = '{2, 1, 16'h0070, 16'h0700, 64'h19,  4, 0};  // hold in IDLE/DRAIN/DONE

    rst_n = 1'b0;
    start = 1'b0;
    hold = 1'b0;
    vec_len = '0;
    num_vec = '0;
    neuron_base = '0;
    weight_base = '0;
    #1;
    check("reset outputs",
          {bus.n_rd_en, bus.w_rd_en, bus.pe_vld, bus.pe_ctl, done, busy, hold_cycles},
          39'd0);
    check("reset addrs", {bus.n_addr, bus.w_addr}, 32'd0);
    #13;
    rst_n = 1'b1;

    for (int t = 0; t < 8; t++) begin
      run_job(tab[t].vl, tab[t].nv, tab[t].nb, tab[t].wb, tab[t].hmask,
              tab[t].exp_done, tab[t].exp_hold, $sformatf("tab%0d", t));
    end

    // Start mid-job is ignored, then reset abandons the job.
    @(posedge clk); #1;
    start = 1'b1; vec_len = 8'd4; num_vec = 8'd2;
    neuron_base = 16'h0010; weight_base = 16'h0100; hold = 1'b0;
    for (int cy = 1; cy <= 4; cy++) begin
      @(posedge clk); #1;
      start = (cy == 3);
      if (cy == 3) begin
        vec_len = 8'd7; num_vec = 8'd9; neuron_base = 16'h0055; weight_base = 16'h0077;
      end
      #1;
      check($sformatf("ignore_start c%0d addr", cy), {bus.n_addr, bus.w_addr},
            {16'h0010 + 16'(cy - 1), 16'h0100 + 16'(cy - 1)});
    end
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset outputs", {bus.pe_vld, bus.pe_ctl, busy, done, bus.n_rd_en}, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(4, 2, 16'h0010, 16'h0100, 64'h0, 10, 0, "after_reset");

    // Random jobs, back to back.
    for (int r = 0; r < 20; r++) begin
      int rl, rm;
      logic [15:0] rnb, rwb;
      logic [63:0] rh;
      rl  = $urandom_range(0, 6);
      rm  = $urandom_range(0, 4);
      rnb = 16'($urandom);
      rwb = ($urandom_range(0, 1) == 1) ? (16'hFFF0 + 16'($urandom_range(0, 15)))
                                        : 16'($urandom);
      rh  = {$urandom, $urandom} & {$urandom, $urandom};
      run_job(rl, rm, rnb, rwb, rh, -1, -1, $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
